digital_clock_core: RTL and testbench
=====================================

# digital_clock_core

Parametrised 24-hour time-of-day core for the watch design: divides the system clock to a 1 Hz tick, keeps hours/minutes/seconds as BCD digit counters, and drives six registered seven-segment digit outputs. Adds runtime 12/24-hour display, edge-detected set buttons, leading-zero blanking, configurable segment polarity, and an optional alarm compare. Sits between the board clock/buttons and the display pins.

## Interface
- TICK_DIV, 50000000, clk cycles per 1 s tick; must be >= 2
- SEG_ACTIVE_LOW, 1, 1 = segment lit when bit is 0; 0 = lit when bit is 1
- clk  in  1  system clock
- rst_n  in  1  reset; one clock; reset is asynchronous and active-low
- time_set  in  1  1 = set mode (time frozen, buttons edit time)
- inc_hr  in  1  hour-increment button, synchronous level
- inc_min  in  1  minute-increment button, synchronous level
- mode_12h  in  1  1 = 12-hour display, 0 = 24-hour display
- alarm_set  in  1  1 = buttons edit alarm, display shows alarm (ALARM_EN only)
- alarm_on  in  1  alarm enable (ALARM_EN only)
- tick  out  1  one-cycle pulse each second
- hr_bcd, min_bcd, sec_bcd  out  8 each  displayed value, {tens,units} BCD
- pm  out  1  PM indicator (12-hour mode only)
- seg_h1, seg_h0, seg_m1, seg_m0, seg_s1, seg_s0  out  7 each  digit segments {g,f,e,d,c,b,a}; *1 = tens
- alarm_hit  out  1  alarm active

## Operation
- Tick counter runs 0..TICK_DIV-1; tick=1 in the cycle the counter equals TICK_DIV-1, then counter wraps to 0.
- Time held as six BCD digits, 24-hour internal: hours 00-23, minutes/seconds 00-59.
- Run mode (time_set=0): each tick increments seconds; 59->00 carries to minutes; minutes 59->00 carries to hours; 23:59:59 -> 00:00:00 in one tick.
- Set mode (time_set=1): tick counter held at 0, tick=0, seconds forced to 00; rising edge of inc_hr: hours +1 mod 24, no carry; rising edge of inc_min: minutes +1 mod 60, no carry to hours; both edges same cycle: both apply.
- Edge detect: one register per button, reset 0; edge = level & ~prev. Edges in run mode (without alarm_set) ignored.
- Leaving set mode: first tick exactly TICK_DIV cycles later.
- Display mapping, mode_12h=1: hour 00 -> 12 pm=0; 01-11 -> same, pm=0; 12 -> 12 pm=1; 13-23 -> h-12, pm=1; hour tens digit 0 blanked (all segments off). mode_12h=0: hours unmodified, pm=0, no blanking.
- Segment codes (active-low form) 0..9: 1000000, 1111001, 0100100, 0110000, 0011001, 0010010, 0000010, 1111000, 0000000, 0010000; inverted when SEG_ACTIVE_LOW=0. Blank = all unlit.

## Timing
- Reset: time 00:00:00, tick counter 0, tick=0, edge registers 0, alarm 00:00, alarm_hit=0, pm=0, all seg outputs = code for "0".
- hr_bcd/min_bcd/sec_bcd/pm: combinational from count registers and mode_12h (zero latency).
- seg_*: registered, one cycle after the BCD outputs change.
- Button edge takes effect at the clock edge where level=1 and prev=0; count visible on BCD outputs that cycle's next edge.
- Reset asserted mid-operation clears everything immediately; first tick TICK_DIV cycles after release.

## Configuration
- ALARM_EN defined: alarm hh:mm registers (24-hour BCD). alarm_set=1 with time_set=0: button edges edit alarm (same wrap rules), time keeps running, BCD/seg outputs show alarm hh:mm and seconds 00. time_set=1 overrides alarm_set. alarm_hit registered: 1 the cycle after alarm_on=1, time_set=0 and current hh:mm equals alarm hh:mm; clears one cycle after any of these fails (i.e. lasts one minute).
- ALARM_EN undefined: no alarm registers; alarm_set and alarm_on ignored; alarm_hit tied 0.

## Test plan
- TICK_DIV=4: release reset -> tick every 4 cycles, first at cycle 4; sec_bcd 8'h01 after first tick; seg_s0=1111001 one cycle later.
- Load 23:59:58 via set mode, run 2 ticks -> 23:59:59 then 00:00:00.
- time_set=1, hold inc_min high 10 cycles -> minutes +1 only; pulse inc_min from 59 -> 00, hours unchanged; inc_hr and inc_min same cycle from 23:59 -> 00:00.
- mode_12h=1 at 00:xx -> hr_bcd 8'h12 pm=0; 13:xx -> 8'h01 pm=1, seg_h1 blank; 12:xx -> 8'h12 pm=1.
- SEG_ACTIVE_LOW=0 -> digit 8 seg = 1111111, blank = 0000000.
- ALARM_EN: alarm 00:01, alarm_on=1, run from 00:00:58 -> alarm_hit rises one cycle after 00:01:00, falls one cycle after 00:02:00; alarm_on=0 mid-minute -> falls next cycle.

Source files
------------

// File: rtl/digital_clock_core.sv
// digital_clock_core
//   24-hour time-of-day core. Divides clk down to a 1 s tick, keeps
//   hh:mm:ss as BCD digit pairs, and drives six registered seven-segment
//   digits. Supports 12/24-hour display, edge-detected set buttons,
//   leading-zero blanking of the hour tens digit in 12-hour mode, and
//   selectable segment polarity.
//
//   Optional feature macro: ALARM_EN (alarm hh:mm registers + alarm_hit).
//
// Parameters
//   TICK_DIV        clk cycles per 1 s tick (>= 2)
//   SEG_ACTIVE_LOW  1 = segment lit on 0, 0 = lit on 1
// Ports
//   clk, rst_n                  clock, async active-low reset
//   time_set                    freeze time, buttons edit time
//   inc_hr, inc_min             increment buttons (levels, edge-detected here)
//   mode_12h                    12-hour display select
//   alarm_set, alarm_on         alarm edit / enable (ALARM_EN builds only)
//   tick                        one-cycle pulse each second
//   hr_bcd, min_bcd, sec_bcd    displayed value, {tens,units}
//   pm                          PM flag (12-hour mode)
//   seg_h1..seg_s0              digit segments {g,f,e,d,c,b,a}
//   alarm_hit                   alarm active
module digital_clock_core #(
    parameter int TICK_DIV       = 50000000,
    parameter bit SEG_ACTIVE_LOW = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       time_set,
    input  logic       inc_hr,
    input  logic       inc_min,
    input  logic       mode_12h,
    input  logic       alarm_set,
    input  logic       alarm_on,
    output logic       tick,
    output logic [7:0] hr_bcd,
    output logic [7:0] min_bcd,
    output logic [7:0] sec_bcd,
    output logic       pm,
    output logic [6:0] seg_h1,
    output logic [6:0] seg_h0,
    output logic [6:0] seg_m1,
    output logic [6:0] seg_m0,
    output logic [6:0] seg_s1,
    output logic [6:0] seg_s0,
    output logic       alarm_hit
);

    localparam int             CW       = $clog2(TICK_DIV);
    localparam logic [CW-1:0]  CNT_LAST = CW'(TICK_DIV - 1);
    localparam logic [6:0]     SEG_ZERO = SEG_ACTIVE_LOW ? 7'b1000000 : 7'b0111111;

    // BCD pair increment that wraps to 00 after 'last'.
    function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] last);
        if (v == last)          return 8'h00;
        else if (v[3:0] == 4'd9) return {v[7:4] + 4'd1, 4'd0};
        else                     return {v[7:4], v[3:0] + 4'd1};
    endfunction

    // Segment code in active-low form, flipped for active-high pins.
    function automatic logic [6:0] seg_code(input logic [3:0] d, input logic blank);
        logic [6:0] al;
        case (d)
            4'd0: al = 7'b1000000;
            4'd1: al = 7'b1111001;
            4'd2: al = 7'b0100100;
            4'd3: al = 7'b0110000;
            4'd4: al = 7'b0011001;
            4'd5: al = 7'b0010010;
            4'd6: al = 7'b0000010;
            4'd7: al = 7'b1111000;
            4'd8: al = 7'b0000000;
            4'd9: al = 7'b0010000;
            default: al = 7'b1111111;
        endcase
        if (blank) al = 7'b1111111;
        return SEG_ACTIVE_LOW ? al : ~al;
    endfunction

    logic [CW-1:0]   cnt_q, cnt_d;
    logic [7:0]      hr_q, hr_d, min_q, min_d, sec_q, sec_d;
    logic            hr_prev_q, hr_prev_d, min_prev_q, min_prev_d;
    logic [5:0][6:0] seg_q, seg_d;
    logic            hr_edge, min_edge;
    logic [7:0]      src_hr, src_min, src_sec;
    logic [4:0]      h_bin, h12;
    logic            blank_h1;

`ifdef ALARM_EN
    logic [7:0] al_hr_q, al_hr_d, al_min_q, al_min_d;
    logic       alarm_hit_q, alarm_hit_d;
`else
    logic       unused_alarm_in;
    assign unused_alarm_in = alarm_set | alarm_on;
`endif

    assign hr_edge  = inc_hr & ~hr_prev_q;
    assign min_edge = inc_min & ~min_prev_q;
    assign tick     = ~time_set & (cnt_q == CNT_LAST);

    // Count / edit next-state.
    always_comb begin
        cnt_d      = cnt_q;
        hr_d       = hr_q;
        min_d      = min_q;
        sec_d      = sec_q;
        hr_prev_d  = inc_hr;
        min_prev_d = inc_min;
`ifdef ALARM_EN
        al_hr_d     = al_hr_q;
        al_min_d    = al_min_q;
        alarm_hit_d = alarm_on & ~time_set & (hr_q == al_hr_q) & (min_q == al_min_q);
`endif
        if (time_set) begin
            // Frozen: divider parked so the first tick lands TICK_DIV cycles after release.
            cnt_d = '0;
            sec_d = 8'h00;
            if (hr_edge)  hr_d  = bcd_inc(hr_q, 8'h23);
            if (min_edge) min_d = bcd_inc(min_q, 8'h59);
        end else begin
            cnt_d = tick ? '0 : cnt_q + 1'b1;
            if (tick) begin
                sec_d = bcd_inc(sec_q, 8'h59);
                if (sec_q == 8'h59) begin
                    min_d = bcd_inc(min_q, 8'h59);
                    if (min_q == 8'h59) hr_d = bcd_inc(hr_q, 8'h23);
                end
            end
`ifdef ALARM_EN
            if (alarm_set) begin
                if (hr_edge)  al_hr_d  = bcd_inc(al_hr_q, 8'h23);
                if (min_edge) al_min_d = bcd_inc(al_min_q, 8'h59);
            end
`endif
        end
    end

    // Display value: source select, then 24 -> 12 hour remap.
    always_comb begin
        src_hr  = hr_q;
        src_min = min_q;
        src_sec = sec_q;
`ifdef ALARM_EN
        if (alarm_set && !time_set) begin
            src_hr  = al_hr_q;
            src_min = al_min_q;
            src_sec = 8'h00;
        end
`endif
        h_bin  = {1'b0, src_hr[7:4]} * 5'd10 + {1'b0, src_hr[3:0]};
        h12    = h_bin;
        pm     = 1'b0;
        hr_bcd = src_hr;
        if (mode_12h) begin
            pm = (h_bin >= 5'd12);
            if (h_bin == 5'd0)       h12 = 5'd12;
            else if (h_bin > 5'd12)  h12 = h_bin - 5'd12;
            hr_bcd = (h12 >= 5'd10) ? {4'd1, h12[3:0] - 4'd10} : {4'd0, h12[3:0]};
        end
        min_bcd  = src_min;
        sec_bcd  = src_sec;
        blank_h1 = mode_12h & (hr_bcd[7:4] == 4'd0);
    end

    always_comb begin
        seg_d[5] = seg_code(hr_bcd[7:4], blank_h1);
        seg_d[4] = seg_code(hr_bcd[3:0], 1'b0);
        seg_d[3] = seg_code(min_bcd[7:4], 1'b0);
        seg_d[2] = seg_code(min_bcd[3:0], 1'b0);
        seg_d[1] = seg_code(sec_bcd[7:4], 1'b0);
        seg_d[0] = seg_code(sec_bcd[3:0], 1'b0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q      <= '0;
            hr_q       <= 8'h00;
            min_q      <= 8'h00;
            sec_q      <= 8'h00;
            hr_prev_q  <= 1'b0;
            min_prev_q <= 1'b0;
            seg_q      <= {6{SEG_ZERO}};
        end else begin
            cnt_q      <= cnt_d;
            hr_q       <= hr_d;
            min_q      <= min_d;
            sec_q      <= sec_d;
            hr_prev_q  <= hr_prev_d;
            min_prev_q <= min_prev_d;
            seg_q      <= seg_d;
        end
    end

`ifdef ALARM_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            al_hr_q     <= 8'h00;
            al_min_q    <= 8'h00;
            alarm_hit_q <= 1'b0;
        end else begin
            al_hr_q     <= al_hr_d;
            al_min_q    <= al_min_d;
            alarm_hit_q <= alarm_hit_d;
        end
    end
    assign alarm_hit = alarm_hit_q;
`else
    assign alarm_hit = 1'b0;
`endif

    assign seg_h1 = seg_q[5];
    assign seg_h0 = seg_q[4];
    assign seg_m1 = seg_q[3];
    assign seg_m0 = seg_q[2];
    assign seg_s1 = seg_q[1];
    assign seg_s0 = seg_q[0];

endmodule

// File: tb/tb_digital_clock_core.sv
// Bench for digital_clock_core: two instances (active-low and active-high
// segments) share one stimulus stream; a time-of-day model kept in plain
// integers predicts every output each cycle, and directed literal checks
// pin the model at the interesting boundaries.
module tb_digital_clock_core;

    localparam int TD = 4;
`ifdef ALARM_EN
    localparam bit HAS_AL = 1'b1;
`else
    localparam bit HAS_AL = 1'b0;
`endif

    logic clk = 1'b0, rst_n = 1'b0, time_set = 1'b0, inc_hr = 1'b0, inc_min = 1'b0;
    logic mode_12h = 1'b0, alarm_set = 1'b0, alarm_on = 1'b0;
    logic tick0, tick1, pm0, pm1, hit0, hit1;
    logic [7:0] hr0, min0, sec0, hr1, min1, sec1;
    logic [5:0][6:0] sg0, sg1;

    digital_clock_core #(.TICK_DIV(TD), .SEG_ACTIVE_LOW(1'b1)) u0 (
        .clk(clk), .rst_n(rst_n), .time_set(time_set), .inc_hr(inc_hr), .inc_min(inc_min),
        .mode_12h(mode_12h), .alarm_set(alarm_set), .alarm_on(alarm_on), .tick(tick0),
        .hr_bcd(hr0), .min_bcd(min0), .sec_bcd(sec0), .pm(pm0),
        .seg_h1(sg0[5]), .seg_h0(sg0[4]), .seg_m1(sg0[3]), .seg_m0(sg0[2]),
        .seg_s1(sg0[1]), .seg_s0(sg0[0]), .alarm_hit(hit0));

    digital_clock_core #(.TICK_DIV(TD), .SEG_ACTIVE_LOW(1'b0)) u1 (
        .clk(clk), .rst_n(rst_n), .time_set(time_set), .inc_hr(inc_hr), .inc_min(inc_min),
        .mode_12h(mode_12h), .alarm_set(alarm_set), .alarm_on(alarm_on), .tick(tick1),
        .hr_bcd(hr1), .min_bcd(min1), .sec_bcd(sec1), .pm(pm1),
        .seg_h1(sg1[5]), .seg_h0(sg1[4]), .seg_m1(sg1[3]), .seg_m0(sg1[2]),
        .seg_s1(sg1[1]), .seg_s0(sg1[0]), .alarm_hit(hit1));

    always #5 clk = ~clk;

    int n_pass = 0, n_tot = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tot++;
        if (act !== exp) $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
        else n_pass++;
    endtask

    // ---------------- model ----------------
    int mh = 0, mm = 0, ms = 0, mdiv = 0, mah = 0, mam = 0;
    bit mph = 0, mpm = 0, mhit = 0;
    logic [5:0][6:0] eseg0 = {6{7'b1000000}}, eseg1 = {6{7'b0111111}};

    function automatic logic [6:0] seg_of(int d, bit blank, bit act_low);
        logic [6:0] c;
        case (d)
            0: c = 7'b1000000; 1: c = 7'b1111001; 2: c = 7'b0100100; 3: c = 7'b0110000;
            4: c = 7'b0011001; 5: c = 7'b0010010; 6: c = 7'b0000010; 7: c = 7'b1111000;
            8: c = 7'b0000000; 9: c = 7'b0010000; default: c = 7'b1111111;
        endcase
        if (blank) c = 7'b1111111;
        return act_low ? c : ~c;
    endfunction

    function automatic logic [5:0][6:0] segs_for(int dh, int dm, int ds, bit blank, bit al);
        logic [5:0][6:0] r;
        r[5] = seg_of(dh / 10, blank, al); r[4] = seg_of(dh % 10, 1'b0, al);
        r[3] = seg_of(dm / 10, 1'b0, al);  r[2] = seg_of(dm % 10, 1'b0, al);
        r[1] = seg_of(ds / 10, 1'b0, al);  r[0] = seg_of(ds % 10, 1'b0, al);
        return r;
    endfunction

    function automatic logic [7:0] to_bcd(int v);
        return 8'(((v / 10) << 4) | (v % 10));
    endfunction

    // What the display should show right now.
    task automatic disp(output int dh, output int dm, output int ds, output bit dpm);
        bit show;
        int h;
        show = HAS_AL && alarm_set && !time_set;
        h    = show ? mah : mh;
        dm   = show ? mam : mm;
        ds   = show ? 0 : ms;
        dpm  = 0;
        dh   = h;
        if (mode_12h) begin
            dpm = (h >= 12);
            dh  = (h % 12 == 0) ? 12 : h % 12;
        end
    endtask

    task automatic model_reset();
        mh = 0; mm = 0; ms = 0; mdiv = 0; mah = 0; mam = 0;
        mph = 0; mpm = 0; mhit = 0;
        eseg0 = {6{7'b1000000}};
        eseg1 = {6{7'b0111111}};
    endtask

    task automatic model_step();
        int dh, dm, ds, t;
        bit dpm, eh, em, tk;
        disp(dh, dm, ds, dpm);
        eseg0 = segs_for(dh, dm, ds, mode_12h && dh < 10, 1'b1);
        eseg1 = segs_for(dh, dm, ds, mode_12h && dh < 10, 1'b0);
        eh = inc_hr && !mph;
        em = inc_min && !mpm;
        mph = inc_hr;
        mpm = inc_min;
        mhit = HAS_AL && alarm_on && !time_set && mh == mah && mm == mam;
        if (time_set) begin
            mdiv = 0;
            ms   = 0;
            if (eh) mh = (mh + 1) % 24;
            if (em) mm = (mm + 1) % 60;
        end else begin
            tk   = (mdiv == TD - 1);
            mdiv = tk ? 0 : mdiv + 1;
            if (tk) begin
                t  = ((mh * 60 + mm) * 60 + ms + 1) % 86400;
                mh = t / 3600;
                mm = (t / 60) % 60;
                ms = t % 60;
            end
            if (HAS_AL && alarm_set) begin
                if (eh) mah = (mah + 1) % 24;
                if (em) mam = (mam + 1) % 60;
            end
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) model_reset();
        else        model_step();
    end

    // Per-cycle comparison, away from the active edge.
    always @(negedge clk) begin
        int dh, dm, ds;
        bit dpm, etick;
        disp(dh, dm, ds, dpm);
        etick = rst_n && !time_set && mdiv == TD - 1;
        chk("tick", {tick0, tick1}, {etick, etick});
        chk("hr_bcd", {hr0, hr1}, {to_bcd(dh), to_bcd(dh)});
        chk("min_bcd", {min0, min1}, {to_bcd(dm), to_bcd(dm)});
        chk("sec_bcd", {sec0, sec1}, {to_bcd(ds), to_bcd(ds)});
        chk("pm", {pm0, pm1}, {dpm, dpm});
        chk("alarm_hit", {hit0, hit1}, {mhit, mhit});
        chk("seg_lo", sg0, eseg0);
        chk("seg_hi", sg1, eseg1);
    end

    // ---------------- stimulus ----------------
    task automatic cyc(int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic press_n(bit h, bit m, int n);
        for (int k = 0; k < n; k++) begin
            inc_hr = h; inc_min = m;
            cyc(1);
            inc_hr = 0; inc_min = 0;
            cyc(1);
        end
    endtask

    initial begin
        cyc(3);
        chk("rst_sec", sec0, 8'h00);
        chk("rst_seg_s0", sg0[0], 7'b1000000);
        chk("rst_seg_h1_hi", sg1[5], 7'b0111111);
        chk("rst_tick", tick0, 1'b0);
        chk("rst_hit", hit0, 1'b0);

        rst_n = 1;
        cyc(3);
        chk("first_tick", tick0, 1'b1);
        cyc(1);
        chk("first_sec", sec0, 8'h01);
        cyc(1);
        chk("first_seg_s0", sg0[0], 7'b1111001);

        // load 23:59:58 and roll over
        time_set = 1;
        press_n(1, 0, 23);
        press_n(0, 1, 59);
        time_set = 0;
        cyc(4 * 58);
        chk("load_235958", {hr0, min0, sec0}, 24'h235958);
        cyc(4);
        chk("run_235959", {hr0, min0, sec0}, 24'h235959);
        cyc(4);
        chk("rollover", {hr0, min0, sec0}, 24'h000000);

        // held button counts once
        time_set = 1;
        inc_min = 1;
        cyc(10);
        inc_min = 0;
        cyc(1);
        chk("held_min", {hr0, min0}, 16'h0001);

        press_n(1, 0, 23);
        press_n(0, 1, 58);
        chk("set_2359", {hr0, min0}, 16'h2359);
        press_n(0, 1, 1);
        chk("min_wrap_no_carry", {hr0, min0}, 16'h2300);
        press_n(0, 1, 59);
        press_n(1, 1, 1);
        chk("both_wrap", {hr0, min0}, 16'h0000);

        // 12-hour display
        mode_12h = 1;
        cyc(1);
        chk("h12_00", {hr0, 7'd0, pm0}, {8'h12, 8'h00});
        press_n(1, 0, 13);
        chk("h12_13", {hr0, 7'd0, pm0}, {8'h01, 8'h01});
        cyc(1);
        chk("blank_lo", sg0[5], 7'b1111111);
        chk("blank_hi", sg1[5], 7'b0000000);
        press_n(1, 0, 23);
        chk("h12_12", {hr0, 7'd0, pm0}, {8'h12, 8'h01});
        press_n(0, 1, 8);
        cyc(1);
        chk("digit8_hi", sg1[2], 7'b1111111);
        chk("digit8_lo", sg0[2], 7'b0000000);
        mode_12h = 0;
        time_set = 0;

        // randomized phase
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 39) == 0) time_set = ~time_set;
            inc_hr  = ($urandom_range(0, 2) == 0);
            inc_min = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 49) == 0) mode_12h = ~mode_12h;
            if ($urandom_range(0, 29) == 0) alarm_set = ~alarm_set;
            if ($urandom_range(0, 29) == 0) alarm_on = ~alarm_on;
            rst_n = (i != 1500);
            cyc(1);
        end
        time_set = 0; inc_hr = 0; inc_min = 0; mode_12h = 0;
        alarm_set = 0; alarm_on = 0; rst_n = 1;
        cyc(2);

`ifdef ALARM_EN
        rst_n = 0;
        cyc(1);
        rst_n = 1;
        alarm_set = 1;
        press_n(0, 1, 1);
        chk("al_disp", {hr0, min0, sec0}, 24'h000100);
        alarm_set = 0;
        time_set = 1;
        cyc(1);
        time_set = 0;
        alarm_on = 1;
        cyc(4 * 58);
        chk("al_pre", {hr0, min0, sec0, 7'd0, hit0}, {24'h000058, 8'h00});
        cyc(8);
        chk("al_edge_time", {hr0, min0, sec0, 7'd0, hit0}, {24'h000100, 8'h00});
        cyc(1);
        chk("al_rise", hit0, 1'b1);
        cyc(239);
        chk("al_hold", hit0, 1'b1);
        cyc(1);
        chk("al_fall", hit0, 1'b0);
        rst_n = 0;
        cyc(1);
        rst_n = 1;
        cyc(10);
        chk("al_match_reset", hit0, 1'b1);
        alarm_on = 0;
        cyc(1);
        chk("al_off", hit0, 1'b0);
`endif

        cyc(2);
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
